// File: rtl/note_length_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : note_length_seq
// Purpose  : Note duration controller for the music game. Pulls note lengths
//            from the note sequencer over a valid/ready request handshake,
//            times each note in beat ticks from an internal tempo prescaler,
//            optionally inserts a silent gap after each note, and pulses
//            led2shift at note start and change at note end.
// Revision : 1.0 - initial single-clock-domain release
// ----------------------------------------------------------------------------
// Ports
//   clk        in   system clock, rising edge
//   rst        in   asynchronous reset, active low
//   start      in   begin a sequence (only honoured while idle)
//   stop       in   abort to idle from any state
//   pause      in   freeze beat timing while high
//   note_len   in   length of offered note in ticks (0 = rest/skip)
//   note_last  in   offered note is the final one of the sequence
//   note_vld   in   note_len / note_last valid
//   note_req   out  ready to accept a note (high while fetching)
//   led2shift  out  one-cycle pulse at the start of each played note
//   change     out  one-cycle pulse at the end of each played note
//   seq_done   out  one-cycle pulse when the last note (and its gap) ends
//   busy       out  high whenever not idle
//   len_cnt    out  ticks elapsed in the current note
//   cur_len    out  latched length of the current note
// ============================================================================
module note_length_seq #(
    parameter int LEN_W     = 4,
    parameter int DIV_W     = 24,
    parameter int TICK_DIV  = 12500000,
    parameter int GAP_TICKS = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic [LEN_W-1:0] note_len,
    input  logic             note_last,
    input  logic             note_vld,
    output logic             note_req,
    output logic             led2shift,
    output logic             change,
    output logic             seq_done,
    output logic             busy,
    output logic [LEN_W-1:0] len_cnt,
    output logic [LEN_W-1:0] cur_len
);

    localparam logic [1:0] c_st_idle  = 2'd0;
    localparam logic [1:0] c_st_fetch = 2'd1;
    localparam logic [1:0] c_st_play  = 2'd2;
    localparam logic [1:0] c_st_gap   = 2'd3;

    localparam logic [DIV_W-1:0] c_tick_max = DIV_W'(TICK_DIV - 1);

    // The gap counter is kept at least one bit wide so the design still
    // elaborates cleanly when no gap is configured.
    localparam int c_gap_w = (GAP_TICKS > 1) ? $clog2(GAP_TICKS + 1) : 1;
    localparam logic [c_gap_w-1:0] c_gap_last =
        c_gap_w'((GAP_TICKS > 0) ? GAP_TICKS - 1 : 0);

    logic [1:0]         r_state;
    logic [DIV_W-1:0]   r_presc;
    logic [LEN_W-1:0]   r_len_cnt;
    logic [LEN_W-1:0]   r_cur_len;
    logic               r_last;
    logic [c_gap_w-1:0] r_gap_cnt;
    logic               r_led;
    logic               r_chg;
    logic               r_done;

    logic               w_tick;
    logic               w_len_end;
    logic               w_gap_end;

    // A beat tick only exists while timing is live; pause freezes it.
    assign w_tick    = ((r_state == c_st_play) || (r_state == c_st_gap)) &&
                       !pause && (r_presc == c_tick_max);
    assign w_len_end = (r_len_cnt == (r_cur_len - LEN_W'(1)));
    assign w_gap_end = (r_gap_cnt == c_gap_last);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state   <= c_st_idle;
            r_presc   <= '0;
            r_len_cnt <= '0;
            r_cur_len <= '0;
            r_last    <= 1'b0;
            r_gap_cnt <= '0;
            r_led     <= 1'b0;
            r_chg     <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_led  <= 1'b0;
            r_chg  <= 1'b0;
            r_done <= 1'b0;
            if (stop) begin
                // Abort wins over everything, including a note-end tick.
                r_state   <= c_st_idle;
                r_presc   <= '0;
                r_len_cnt <= '0;
                r_gap_cnt <= '0;
            end else begin
                case (r_state)
                    c_st_idle: begin
                        if (start) begin
                            r_state <= c_st_fetch;
                        end
                    end
                    c_st_fetch: begin
                        if (note_vld) begin
                            r_cur_len <= note_len;
                            r_last    <= note_last;
                            if (note_len != '0) begin
                                r_state   <= c_st_play;
                                r_len_cnt <= '0;
                                r_presc   <= '0;
                                r_led     <= 1'b1;
                            end else if (note_last) begin
                                // Zero-length final note: finish silently.
                                r_state <= c_st_idle;
                                r_done  <= 1'b1;
                            end
                        end
                    end
                    c_st_play: begin
                        if (!pause) begin
                            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
                        end
                        if (w_tick) begin
                            if (w_len_end) begin
                                // The ending tick does not advance len_cnt, so it
                                // never passes cur_len-1 and never wraps.
                                r_chg     <= 1'b1;
                                r_len_cnt <= '0;
                                if (GAP_TICKS > 0) begin
                                    r_state   <= c_st_gap;
                                    r_gap_cnt <= '0;
                                end else if (r_last) begin
                                    r_state <= c_st_idle;
                                    r_done  <= 1'b1;
                                end else begin
                                    r_state <= c_st_fetch;
                                end
                            end else begin
                                r_len_cnt <= r_len_cnt + LEN_W'(1);
                            end
                        end
                    end
                    c_st_gap: begin
                        if (!pause) begin
                            r_presc <= w_tick ? '0 : r_presc + DIV_W'(1);
                        end
                        if (w_tick) begin
                            if (w_gap_end) begin
                                r_gap_cnt <= '0;
                                r_state   <= r_last ? c_st_idle : c_st_fetch;
                                r_done    <= r_last;
                            end else begin
                                r_gap_cnt <= r_gap_cnt + c_gap_w'(1);
                            end
                        end
                    end
                    default: begin
                        r_state <= c_st_idle;
                    end
                endcase
            end
        end
    end

    // Request and busy are plain decodes of the registered state. With
    // note_vld already high the fetch lasts one cycle, so the next note's
    // led2shift lands two edges after the ending tick of the previous note.
    assign note_req  = (r_state == c_st_fetch);
    assign busy      = (r_state != c_st_idle);
    assign led2shift = r_led;
    assign change    = r_chg;
    assign seq_done  = r_done;
    assign len_cnt   = r_len_cnt;
    assign cur_len   = r_cur_len;

endmodule
`default_nettype wire

// File: tb/tb_note_length_seq.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_note_length_seq
// Purpose  : Self-checking bench for note_length_seq. Two instances share the
//            stimulus: one without a gap, one with a two-tick gap. Note
//            sequences come from a record table; expected pulse times are
//            pushed to a scoreboard queue and popped as pulses appear.
// Revision : 1.0 - initial release
// ============================================================================
module tb_note_length_seq;

    localparam int TD = 4;

    logic       clk = 1'b0;
    logic       rst, start, stop, pause, note_last, note_vld;
    logic [3:0] note_len;

    logic       a_req, a_led, a_chg, a_done, a_busy;
    logic [3:0] a_len_cnt, a_cur_len;
    logic       b_req, b_led, b_chg, b_done, b_busy;
    logic [3:0] b_len_cnt, b_cur_len;

    always #5 clk = ~clk;

    note_length_seq #(.LEN_W(4), .DIV_W(24), .TICK_DIV(TD), .GAP_TICKS(0)) u_dut_a (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .note_len(note_len), .note_last(note_last), .note_vld(note_vld),
        .note_req(a_req), .led2shift(a_led), .change(a_chg), .seq_done(a_done),
        .busy(a_busy), .len_cnt(a_len_cnt), .cur_len(a_cur_len));

    note_length_seq #(.LEN_W(4), .DIV_W(24), .TICK_DIV(TD), .GAP_TICKS(2)) u_dut_b (
        .clk(clk), .rst(rst), .start(start), .stop(stop), .pause(pause),
        .note_len(note_len), .note_last(note_last), .note_vld(note_vld),
        .note_req(b_req), .led2shift(b_led), .change(b_chg), .seq_done(b_done),
        .busy(b_busy), .len_cnt(b_len_cnt), .cur_len(b_cur_len));

    // Observed instance selected by sel.
    bit         sel = 1'b0;
    logic       m_req, m_led, m_chg, m_done, m_busy;
    logic [3:0] m_len_cnt, m_cur_len;
    assign m_req     = sel ? b_req     : a_req;
    assign m_led     = sel ? b_led     : a_led;
    assign m_chg     = sel ? b_chg     : a_chg;
    assign m_done    = sel ? b_done    : a_done;
    assign m_busy    = sel ? b_busy    : a_busy;
    assign m_len_cnt = sel ? b_len_cnt : a_len_cnt;
    assign m_cur_len = sel ? b_cur_len : a_cur_len;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        int         grp;
        logic [3:0] len;
        logic       last;
        int         dur;   // expected cycles from led2shift to change
    } vec_t;

    typedef struct {
        int kind;          // 0 led2shift, 1 change, 2 seq_done
        int at;
    } ev_t;

    vec_t vec[16];
    int   nvec = 0;
    vec_t act[$];
    ev_t  sb[$];

    int   errors = 0;
    int   checks = 0;
    bit   feed_en = 1'b0;
    bit   prev_req = 1'b0;
    int   fidx = 0;

    function automatic string kname(input int k);
        return (k == 0) ? "led2shift" : (k == 1) ? "change" : "seq_done";
    endfunction

    task automatic add(input int g, input logic [3:0] l, input logic last, input int d);
        vec[nvec] = '{g, l, last, d};
        nvec++;
    endtask

    task automatic chk(input string name, input logic [31:0] act_v, input logic [31:0] exp_v);
        checks++;
        if (act_v !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act_v, exp_v, cyc);
        end
    endtask

    task automatic mon(input int kind, input logic p);
        ev_t e;
        if (p) begin
            checks++;
            if (sb.size() == 0) begin
                errors++;
                $display("FAIL %s: unexpected pulse at cyc %0d, none expected", kname(kind), cyc);
            end else begin
                e = sb.pop_front();
                if (e.kind != kind || e.at != cyc) begin
                    errors++;
                    $display("FAIL %s: pulse at cyc %0d, expected %s at cyc %0d",
                             kname(kind), cyc, kname(e.kind), e.at);
                end
            end
        end
    endtask

    // One clock: sample at the falling edge, score pulses, advance the feeder.
    task automatic step();
        ev_t e;
        @(negedge clk);
        while (sb.size() > 0 && sb[0].at < cyc) begin
            e = sb.pop_front();
            checks++;
            errors++;
            $display("FAIL %s: missing pulse, expected at cyc %0d", kname(e.kind), e.at);
        end
        mon(0, m_led);
        mon(1, m_chg);
        mon(2, m_done);
        if (feed_en && prev_req && note_vld) begin
            fidx++;
            if (fidx < act.size()) begin
                note_len  = act[fidx].len;
                note_last = act[fidx].last;
            end else begin
                note_vld = 1'b0;
            end
        end
        prev_req = m_req;
    endtask

    task automatic push(input int kind, input int at, input int f, input int stop_rel,
                        input int pr, input int pl);
        if (pl > 0 && at > f + pr) at += pl;
        if (stop_rel >= 0 && at > f + stop_rel) return;
        sb.push_back('{kind, at});
    endtask

    task automatic quiesce();
        stop = 1'b1;
        step();
        stop = 1'b0;
    endtask

    // Play table group grp on instance dut. gap_cyc: gap length in cycles.
    // stop_rel >= 0 raises stop in that cycle (relative to first FETCH cycle).
    // pause is held for pl cycles from cycle pr, with len_cnt expected at pexp.
    task automatic run_seq(input int grp, input bit dut, input int gap_cyc,
                           input int stop_rel, input int pr, input int pl, input int pexp);
        int f, t, rel;
        bit finished;
        quiesce();
        sel = dut;
        act.delete();
        foreach (vec[i]) if (i < nvec && vec[i].grp == grp) act.push_back(vec[i]);
        f = cyc + 1;
        t = f;
        foreach (act[i]) begin
            if (act[i].len == 4'd0) begin
                if (act[i].last) push(2, t + 1, f, stop_rel, pr, pl);
                else t = t + 1;
            end else begin
                push(0, t + 1, f, stop_rel, pr, pl);
                push(1, t + 1 + act[i].dur, f, stop_rel, pr, pl);
                t = t + 1 + act[i].dur + gap_cyc;
                if (act[i].last) push(2, t, f, stop_rel, pr, pl);
            end
        end
        note_len  = act[0].len;
        note_last = act[0].last;
        note_vld  = 1'b1;
        fidx      = 0;
        prev_req  = 1'b0;
        feed_en   = 1'b1;
        start     = 1'b1;
        step();
        start = 1'b0;
        chk($sformatf("g%0d_fetch_req", grp), 32'(m_req), 32'd1);
        chk($sformatf("g%0d_fetch_busy", grp), 32'(m_busy), 32'd1);
        chk($sformatf("g%0d_fetch_len_cnt", grp), 32'(m_len_cnt), 32'd0);
        finished = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rel = cyc - f;
            pause = (pl > 0 && rel >= pr && rel < pr + pl);
            if (pause) chk($sformatf("g%0d_pause_len_cnt", grp), 32'(m_len_cnt), 32'(pexp));
            if (stop_rel >= 0 && rel == stop_rel) stop = 1'b1;
            if (stop_rel >= 0 && rel == stop_rel + 1) begin
                stop = 1'b0;
                chk("stop_busy", 32'(m_busy), 32'd0);
                chk("stop_req", 32'(m_req), 32'd0);
                chk("stop_len_cnt", 32'(m_len_cnt), 32'd0);
            end
            if ((stop_rel >= 0) ? (rel >= stop_rel + 4) : (sb.size() == 0)) begin
                finished = 1'b1;
                break;
            end
            step();
        end
        pause    = 1'b0;
        stop     = 1'b0;
        feed_en  = 1'b0;
        note_vld = 1'b0;
        checks++;
        if (!finished || sb.size() != 0) begin
            errors++;
            $display("FAIL g%0d_timeout: %0d expected pulses outstanding", grp, sb.size());
            sb.delete();
        end
        if (stop_rel < 0) begin
            step();
            chk($sformatf("g%0d_busy_after_done", grp), 32'(m_busy), 32'd0);
            chk($sformatf("g%0d_req_after_done", grp), 32'(m_req), 32'd0);
            chk($sformatf("g%0d_cur_len", grp), 32'(m_cur_len), 32'(act[act.size()-1].len));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int f;
        add(0, 4'd3, 1'b0, 12); add(0, 4'd2, 1'b0, 8); add(0, 4'd1, 1'b1, 4);
        add(1, 4'd2, 1'b0, 8);  add(1, 4'd2, 1'b1, 8);
        add(2, 4'd1, 1'b0, 4);  add(2, 4'd0, 1'b0, 0); add(2, 4'd2, 1'b0, 8);
        add(2, 4'd0, 1'b1, 0);
        add(3, 4'd3, 1'b1, 12);
        add(4, 4'd1, 1'b0, 4);  add(4, 4'd2, 1'b0, 8); add(4, 4'd1, 1'b1, 4);
        add(5, 4'd1, 1'b1, 4);
        add(6, 4'd15, 1'b1, 60);
        add(7, 4'd2, 1'b1, 8);

        rst = 1'b0; start = 1'b0; stop = 1'b0; pause = 1'b0;
        note_len = 4'd0; note_last = 1'b0; note_vld = 1'b0;
        step();
        step();
        chk("reset_a", {a_req, a_led, a_chg, a_done, a_busy, a_len_cnt, a_cur_len}, 32'd0);
        chk("reset_b", {b_req, b_led, b_chg, b_done, b_busy, b_len_cnt, b_cur_len}, 32'd0);
        rst = 1'b1;
        step();

        run_seq(0, 1'b0, 0, -1, 0, 0, 0);        // back-to-back notes 3,2,1
        run_seq(1, 1'b1, 2 * TD, -1, 0, 0, 0);   // two-tick gap
        run_seq(2, 1'b0, 0, -1, 0, 0, 0);        // zero-length rests
        run_seq(3, 1'b0, 0, -1, 5, 5, 1);        // pause mid-note
        run_seq(4, 1'b0, 0, 13, 0, 0, 0);        // stop on ending tick of note 2
        run_seq(5, 1'b0, 0, -1, 0, 0, 0);        // restart after stop
        run_seq(6, 1'b0, 0, -1, 0, 0, 0);        // maximum length note

        // stop and start together while idle: stop wins
        sel = 1'b0;
        stop = 1'b1; start = 1'b1;
        step();
        stop = 1'b0; start = 1'b0;
        chk("stop_start_busy", 32'(m_busy), 32'd0);
        chk("stop_start_req", 32'(m_req), 32'd0);

        // asynchronous reset in the middle of a note
        quiesce();
        sel = 1'b0;
        note_len = 4'd3; note_last = 1'b1; note_vld = 1'b1;
        f = cyc + 1;
        sb.push_back('{0, f + 1});
        start = 1'b1;
        step();
        start = 1'b0;
        repeat (6) step();
        chk("mid_note_len_cnt", 32'(m_len_cnt), 32'd1);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_outputs", {a_req, a_led, a_chg, a_done, a_busy, a_len_cnt, a_cur_len}, 32'd0);
        sb.delete();
        step();
        step();
        rst = 1'b1;
        repeat (4) step();
        chk("post_rst_idle_busy", 32'(m_busy), 32'd0);
        chk("post_rst_vld_ignored", 32'(m_cur_len), 32'd0);
        note_vld = 1'b0;
        run_seq(7, 1'b0, 0, -1, 0, 0, 0);        // resume after reset

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
